caf_sweep_ctrl: RTL and testbench

Sequencer for the CAF frequency sweep around one `caf_slice`. For each of `num_bins` Doppler bins it programs the slice's frequency shifter and streams one correlation window of `length` sample pairs through it. It then collects the slice's peak (`out_max`, `index`) and tracks the best bin over the sweep. It sits between the sample buffer and `caf_slice`, and reports one winning (bin, lag, magnitude) per sweep.

---
 rtl/caf_pkg.sv | 14 +
 rtl/caf_sweep_ctrl_if.sv | 28 ++
 rtl/caf_max_tracker.sv | 53 +++++
 rtl/caf_sweep_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_caf_sweep_ctrl.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/caf_pkg.sv
// Shared definitions for the CAF sweep controller: FSM encodings and default sweep geometry.
package caf_pkg;

  localparam int CAF_NUM_BINS = 8;
  localparam int CAF_LENGTH   = 5;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CONFIG  = 3'd1;
  localparam logic [2:0] ST_STREAM  = 3'd2;
  localparam logic [2:0] ST_WAIT    = 3'd3;
  localparam logic [2:0] ST_COMPARE = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

endpackage

// File: rtl/caf_sweep_ctrl_if.sv
// Controller <-> caf_slice link: frequency programming, sample stream and result handshake.
interface caf_sweep_ctrl_if #(
  parameter int PHASE_BITS          = 10,
  parameter int LENGTH_COUNTER_BITS = 3,
  parameter int OUT_MAX_BITS        = 5
);
  logic [PHASE_BITS-1:0]          slc_freq_step;
  logic                           slc_freq_step_valid;
  logic                           slc_neg_shift;
  logic                           slc_m_axis_tvalid;
  logic                           slc_s_axis_tready;
  logic                           slc_s_axis_tvalid;
  logic                           slc_m_axis_tready;
  logic [OUT_MAX_BITS-1:0]        slc_out_max;
  logic [LENGTH_COUNTER_BITS-1:0] slc_index;

  modport master (
    output slc_freq_step, slc_freq_step_valid, slc_neg_shift,
           slc_m_axis_tvalid, slc_m_axis_tready,
    input  slc_s_axis_tready, slc_s_axis_tvalid, slc_out_max, slc_index
  );

  modport slave (
    input  slc_freq_step, slc_freq_step_valid, slc_neg_shift,
           slc_m_axis_tvalid, slc_m_axis_tready,
    output slc_s_axis_tready, slc_s_axis_tvalid, slc_out_max, slc_index
  );
endinterface

// File: rtl/caf_max_tracker.sv
// Keeps the best (magnitude, lag, bin) seen in a sweep; ties keep the earlier entry.
module caf_max_tracker #(
  parameter int OUT_MAX_BITS        = 5,
  parameter int LENGTH_COUNTER_BITS = 3,
  parameter int BIN_BITS            = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clear,
  input  logic                           capture,
  input  logic                           first,
  input  logic [OUT_MAX_BITS-1:0]        mag,
  input  logic [LENGTH_COUNTER_BITS-1:0] lag,
  input  logic [BIN_BITS-1:0]            bin,
  output logic [OUT_MAX_BITS-1:0]        best_max,
  output logic [LENGTH_COUNTER_BITS-1:0] best_index,
  output logic [BIN_BITS-1:0]            best_bin
);
  logic [OUT_MAX_BITS-1:0]        max_q, max_d;
  logic [LENGTH_COUNTER_BITS-1:0] idx_q, idx_d;
  logic [BIN_BITS-1:0]            bin_q, bin_d;

  always_comb begin
    max_d = max_q;
    idx_d = idx_q;
    bin_d = bin_q;
    if (clear) begin
      max_d = '0;
      idx_d = '0;
      bin_d = '0;
    end else if (capture && (first || (mag > max_q))) begin
      max_d = mag;
      idx_d = lag;
      bin_d = bin;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      max_q <= '0;
      idx_q <= '0;
      bin_q <= '0;
    end else begin
      max_q <= max_d;
      idx_q <= idx_d;
      bin_q <= bin_d;
    end
  end

  assign best_max   = max_q;
  assign best_index = idx_q;
  assign best_bin   = bin_q;
endmodule

// File: rtl/caf_sweep_ctrl.sv
// CAF Doppler sweep sequencer around one caf_slice.
// Optional WAIT watchdog enabled by defining CAF_SWEEP_TIMEOUT_EN.
//   state   | meaning
//   IDLE    | waiting for start
//   CONFIG  | present freq_step to slice, clear sample counter
//   STREAM  | forward length sample pairs
//   WAIT    | wait for slice result
//   COMPARE | update best_* and step to next bin
//   DONE    | one-cycle done pulse
module caf_sweep_ctrl
  import caf_pkg::*;
#(
  parameter int PHASE_BITS          = 10,
  parameter int LENGTH              = CAF_LENGTH,
  parameter int LENGTH_COUNTER_BITS = 3,
  parameter int OUT_MAX_BITS        = 5,
  parameter int NUM_BINS            = CAF_NUM_BINS,
  parameter int BIN_BITS            = 3
`ifdef CAF_SWEEP_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES    = 64
`endif
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [PHASE_BITS-1:0]          freq_base,
  input  logic                           src_tvalid,
  output logic                           src_tready,
  caf_sweep_ctrl_if.master               slc,
  output logic                           busy,
  output logic                           done,
  output logic [OUT_MAX_BITS-1:0]        best_max,
  output logic [LENGTH_COUNTER_BITS-1:0] best_index,
  output logic [BIN_BITS-1:0]            best_bin,
  output logic                           err
);
  localparam int HALF = NUM_BINS / 2;
  localparam logic [BIN_BITS-1:0]            HALF_BIN = BIN_BITS'(HALF);
  localparam logic [BIN_BITS-1:0]            LAST_BIN = BIN_BITS'(NUM_BINS - 1);
  localparam logic [LENGTH_COUNTER_BITS-1:0] LAST_CNT = LENGTH_COUNTER_BITS'(LENGTH - 1);

  logic [2:0]                     state_q, state_d;
  logic [BIN_BITS-1:0]            bin_q, bin_d, next_bin;
  logic [LENGTH_COUNTER_BITS-1:0] cnt_q, cnt_d;
  logic [PHASE_BITS-1:0]          base_q, base_d, step_q, step_d;
  logic                           neg_q, neg_d, have_q, have_d;
  logic [OUT_MAX_BITS-1:0]        res_max_q, res_max_d;
  logic [LENGTH_COUNTER_BITS-1:0] res_idx_q, res_idx_d;
  logic                           clear, capture, advance;
`ifdef CAF_SWEEP_TIMEOUT_EN
  localparam int WDOG_BITS = $clog2(TIMEOUT_CYCLES + 1);
  logic [WDOG_BITS-1:0] wdog_q, wdog_d;
  logic                 err_q, err_d;
`endif

  assign next_bin = bin_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    cnt_d     = cnt_q;
    base_d    = base_q;
    step_d    = step_q;
    neg_d     = neg_q;
    have_d    = have_q;
    res_max_d = res_max_q;
    res_idx_d = res_idx_q;
    clear     = 1'b0;
    capture   = 1'b0;
    advance   = 1'b0;
`ifdef CAF_SWEEP_TIMEOUT_EN
    wdog_d    = wdog_q;
    err_d     = err_q;
`endif
    case (state_q)
      ST_IDLE: if (start) begin
        state_d = ST_CONFIG;
        bin_d   = '0;
        base_d  = freq_base;
        // Bin 0 sits HALF steps below centre; later bins walk the magnitude by one base step.
        step_d  = PHASE_BITS'(freq_base * HALF);
        neg_d   = 1'b1;
        have_d  = 1'b0;
        clear   = 1'b1;
`ifdef CAF_SWEEP_TIMEOUT_EN
        err_d   = 1'b0;
`endif
      end
      ST_CONFIG: begin
        cnt_d   = '0;
        state_d = ST_STREAM;
      end
      ST_STREAM: if (src_tvalid && slc.slc_s_axis_tready) begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          state_d = ST_WAIT;
`ifdef CAF_SWEEP_TIMEOUT_EN
          wdog_d  = WDOG_BITS'(TIMEOUT_CYCLES - 1);
`endif
        end
      end
      ST_WAIT: begin
        if (slc.slc_s_axis_tvalid) begin
          res_max_d = slc.slc_out_max;
          res_idx_d = slc.slc_index;
          state_d   = ST_COMPARE;
        end
`ifdef CAF_SWEEP_TIMEOUT_EN
        else if (wdog_q == '0) begin
          err_d   = 1'b1;
          advance = 1'b1;
        end else begin
          wdog_d = wdog_q - 1'b1;
        end
`endif
      end
      ST_COMPARE: begin
        capture = 1'b1;
        have_d  = 1'b1;
        advance = 1'b1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (advance) begin
      if (bin_q == LAST_BIN) begin
        state_d = ST_DONE;
      end else begin
        state_d = ST_CONFIG;
        bin_d   = next_bin;
        neg_d   = (next_bin < HALF_BIN);
        step_d  = (bin_q < HALF_BIN) ? (step_q - base_q) : (step_q + base_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bin_q     <= '0;
      cnt_q     <= '0;
      base_q    <= '0;
      step_q    <= '0;
      neg_q     <= 1'b0;
      have_q    <= 1'b0;
      res_max_q <= '0;
      res_idx_q <= '0;
`ifdef CAF_SWEEP_TIMEOUT_EN
      wdog_q    <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      cnt_q     <= cnt_d;
      base_q    <= base_d;
      step_q    <= step_d;
      neg_q     <= neg_d;
      have_q    <= have_d;
      res_max_q <= res_max_d;
      res_idx_q <= res_idx_d;
`ifdef CAF_SWEEP_TIMEOUT_EN
      wdog_q    <= wdog_d;
      err_q     <= err_d;
`endif
    end
  end

  caf_max_tracker #(
    .OUT_MAX_BITS       (OUT_MAX_BITS),
    .LENGTH_COUNTER_BITS(LENGTH_COUNTER_BITS),
    .BIN_BITS           (BIN_BITS)
  ) u_tracker (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .capture   (capture),
    .first     (!have_q),
    .mag       (res_max_q),
    .lag       (res_idx_q),
    .bin       (bin_q),
    .best_max  (best_max),
    .best_index(best_index),
    .best_bin  (best_bin)
  );

  assign src_tready              = (state_q == ST_STREAM) && slc.slc_s_axis_tready;
  assign slc.slc_m_axis_tvalid   = (state_q == ST_STREAM) && src_tvalid;
  assign slc.slc_m_axis_tready   = (state_q == ST_WAIT);
  assign slc.slc_freq_step_valid = (state_q == ST_CONFIG);
  assign slc.slc_freq_step       = step_q;
  assign slc.slc_neg_shift       = neg_q;
  assign busy                    = (state_q != ST_IDLE);
  assign done                    = (state_q == ST_DONE);
`ifdef CAF_SWEEP_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_caf_sweep_ctrl.sv
// Directed bench for caf_sweep_ctrl: frequency mapping, streaming, result tracking, reset.
module tb_caf_sweep_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [9:0] freq_base = '0;
  logic       src_tvalid = 1'b0;
  logic       src_tready;
  logic       busy, done, err;
  logic [4:0] best_max;
  logic [2:0] best_index, best_bin;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;

  caf_sweep_ctrl_if #(.PHASE_BITS(10), .LENGTH_COUNTER_BITS(3), .OUT_MAX_BITS(5)) slc_if ();

  caf_sweep_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .freq_base (freq_base),
    .src_tvalid(src_tvalid),
    .src_tready(src_tready),
    .slc       (slc_if.master),
    .busy      (busy),
    .done      (done),
    .best_max  (best_max),
    .best_index(best_index),
    .best_bin  (best_bin),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_best_max"}, best_max, 0);
    check({tag, "_best_index"}, best_index, 0);
    check({tag, "_best_bin"}, best_bin, 0);
    check({tag, "_freq_step"}, slc_if.slc_freq_step, 0);
    check({tag, "_neg_shift"}, slc_if.slc_neg_shift, 0);
    check({tag, "_freq_valid"}, slc_if.slc_freq_step_valid, 0);
    check({tag, "_m_tvalid"}, slc_if.slc_m_axis_tvalid, 0);
    check({tag, "_m_tready"}, slc_if.slc_m_axis_tready, 0);
    check({tag, "_src_tready"}, src_tready, 0);
  endtask

  // mode 0: continuous, 1: src_tvalid toggling, 2: slice stall for 3 cycles.
  // Returns at the negedge where the controller sits in COMPARE.
  task automatic run_bin(input int b, input int mode, input int base,
                         input logic [4:0] mx, input logic [2:0] ix);
    int waits = 0;
    int acc = 0;
    int cyc = 0;
    int mag = (b < 4) ? (4 - b) : (b - 4);
    int exp_step = (base * mag) % 1024;
    int exp_cyc = (mode == 1) ? 9 : (mode == 2) ? 8 : 5;
    while (!slc_if.slc_freq_step_valid && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    check("cfg_seen", slc_if.slc_freq_step_valid, 1);
    check("freq_step", slc_if.slc_freq_step, exp_step);
    check("neg_shift", slc_if.slc_neg_shift, (b < 4) ? 1 : 0);
    @(negedge clk);
    while (acc < 5 && cyc < 40) begin
      src_tvalid = (mode == 1) ? ((cyc % 2) == 0) : 1'b1;
      slc_if.slc_s_axis_tready = !(mode == 2 && cyc >= 2 && cyc <= 4);
      #1;
      if (mode == 2 && cyc >= 2 && cyc <= 4) check("stall_src_tready", src_tready, 0);
      if (cyc == 0) begin
        check("stream_m_tvalid", slc_if.slc_m_axis_tvalid, src_tvalid);
        check("stream_no_cfg", slc_if.slc_freq_step_valid, 0);
      end
      if (src_tready && src_tvalid) acc++;
      cyc++;
      @(negedge clk);
    end
    src_tvalid = 1'b0;
    slc_if.slc_s_axis_tready = 1'b1;
    check("accepted", acc, 5);
    check("stream_cycles", cyc, exp_cyc);
    check("wait_ready", slc_if.slc_m_axis_tready, 1);
    check("step_hold", slc_if.slc_freq_step, exp_step);
    @(negedge clk);
    check("wait_ready2", slc_if.slc_m_axis_tready, 1);
    slc_if.slc_s_axis_tvalid = 1'b1;
    slc_if.slc_out_max = mx;
    slc_if.slc_index = ix;
    @(negedge clk);
    slc_if.slc_s_axis_tvalid = 1'b0;
    slc_if.slc_out_max = 5'd31;
    slc_if.slc_index = 3'd5;
    check("compare_ready_low", slc_if.slc_m_axis_tready, 0);
    check("compare_busy", busy, 1);
  endtask

  logic [4:0] mx1 [8] = '{5'd3, 5'd7, 5'd7, 5'd2, 5'd9, 5'd9, 5'd1, 5'd4};

  initial begin
    slc_if.slc_s_axis_tready = 1'b1;
    slc_if.slc_s_axis_tvalid = 1'b0;
    slc_if.slc_out_max = '0;
    slc_if.slc_index = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_zero("reset");

    // Sweep 1: base 10, mixed stream patterns, peak at bins 4/5 tie.
    freq_base = 10'd10;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("config_latency", slc_if.slc_freq_step_valid, 1);
    check("busy_after_start", busy, 1);
    for (int b = 0; b < 8; b++)
      run_bin(b, (b == 1) ? 1 : (b == 2) ? 2 : 0, 10, mx1[b], 3'(b));
    @(negedge clk);
    check("done_pulse", done, 1);
    check("s1_best_max", best_max, 9);
    check("s1_best_bin", best_bin, 4);
    check("s1_best_index", best_index, 4);
    check("s1_err", err, 0);
    @(negedge clk);
    check("done_low", done, 0);
    check("idle_busy", busy, 0);
    repeat (4) @(negedge clk);
    check("s1_done_count", done_cnt, 1);
    check("hold_best_max", best_max, 9);
    check("hold_best_bin", best_bin, 4);

    // Sweep 2: start clears best, freq_base sampled once, equal results keep bin 0.
    freq_base = 10'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_clears_max", best_max, 0);
    check("start_clears_bin", best_bin, 0);
    freq_base = 10'd99;
    for (int b = 0; b < 8; b++) begin
      start = (b >= 2 && b <= 5);
      run_bin(b, 0, 3, 5'd5, 3'(7 - b));
    end
    start = 1'b0;
    @(negedge clk);
    check("s2_done", done, 1);
    check("s2_best_max", best_max, 5);
    check("s2_best_bin", best_bin, 0);
    check("s2_best_index", best_index, 7);
    repeat (3) @(negedge clk);
    check("s2_busy", busy, 0);
    check("s2_done_count", done_cnt, 2);

    // Sweep 3: reset in bin 3 after two accepted samples.
    freq_base = 10'd10;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int b = 0; b < 3; b++) run_bin(b, 0, 10, 5'd20, 3'd1);
    @(negedge clk);
    check("s3_cfg_bin3", slc_if.slc_freq_step_valid, 1);
    check("s3_step_bin3", slc_if.slc_freq_step, 10);
    @(negedge clk);
    src_tvalid = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_zero("midrst");
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_busy", busy, 0);
    check("post_rst_src_tready", src_tready, 0);
    src_tvalid = 1'b0;
    check("s3_done_count", done_cnt, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
